// File: rtl/mem_stage_pkg.sv
// Shared types for the RV64 MEM stage: datapath width, FSM state encoding
// and the MEM/WB pipeline bundle with its bubble value.
package mem_stage_pkg;

  localparam int XLEN = 64;

  // FSM state encoding kept as plain constants for compatibility with older tools
  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t WAIT = 1'b1;

  // Everything the MEM/WB register carries toward writeback
  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] read_data;
    logic            misalign;
  } mem_wb_t;

  // A bubble must never write the register file or raise a trap
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with load enable and bubble insertion.
// A bubble takes priority over a load so a stalled instruction never retires twice.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    load_en,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  // Capture the next bundle, squash it to a bubble, or hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (bubble) begin
      q <= MEM_WB_BUBBLE;
    end else if (load_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV64 MEM stage: doubleword loads/stores over a req/ack data-memory port.
// Stalls upstream while an access is outstanding; ALU results pass in one cycle.
// Optional feature: define MISALIGN_TRAP_EN to trap accesses whose low three
// address bits are nonzero instead of silently truncating them.
// XLEN must match mem_stage_pkg::XLEN because the MEM/WB bundle uses it.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteM,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic              MemToRegM,
  input  logic [4:0]        RD_M,
  input  logic [XLEN_P-1:0] ALU_ResultM,
  input  logic [XLEN_P-1:0] WriteDataM,
  output logic              StallM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN_P-1:0] dmem_wdata,
  input  logic [XLEN_P-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [4:0]        RD_W,
  output logic [XLEN_P-1:0] ALU_ResultW,
  output logic [XLEN_P-1:0] ReadDataW,
  output logic              MisalignW
);

  state_t  state;
  logic    mem_op;
  logic    misaligned;
  logic    issue;
  logic    done;
  mem_wb_t wb_next;
  mem_wb_t wb_q;
  logic    unused_addr_bits;

  // A load with the write bit also set is treated as a plain load
  assign mem_op = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = mem_op & (ALU_ResultM[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  // Only the doubleword index reaches the memory port
  assign unused_addr_bits = ^{ALU_ResultM[XLEN_P-1:ADDR_W+3], ALU_ResultM[2:0]};

  assign issue  = (state == IDLE) && mem_op && !misaligned;
  assign done   = (state == WAIT) && dmem_ack;
  assign StallM = issue || ((state == WAIT) && !dmem_ack);

  // Request FSM: latch the access on issue, hold it steady until ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else if (issue) begin
      state      <= WAIT;
      dmem_req   <= 1'b1;
      dmem_we    <= MemWriteM & ~MemReadM;
      dmem_addr  <= ALU_ResultM[ADDR_W+2:3];
      dmem_wdata <= WriteDataM;
    end else if (done) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
    end
  end

  // Assemble the writeback bundle; load data is only meaningful on the ack cycle
  always_comb begin
    wb_next            = MEM_WB_BUBBLE;
    wb_next.reg_write  = RegWriteM & ~misaligned;
    wb_next.mem_to_reg = MemToRegM;
    wb_next.rd         = RD_M;
    wb_next.alu_result = ALU_ResultM;
    wb_next.read_data  = (done && !dmem_we) ? dmem_rdata : '0;
    wb_next.misalign   = misaligned;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk     (clk),
    .reset   (reset),
    .load_en (!StallM),
    .bubble  (StallM),
    .d       (wb_next),
    .q       (wb_q)
  );

  assign RegWriteW   = wb_q.reg_write;
  assign MemToRegW   = wb_q.mem_to_reg;
  assign RD_W        = wb_q.rd;
  assign ALU_ResultW = wb_q.alu_result;
  assign ReadDataW   = wb_q.read_data;
  assign MisalignW   = wb_q.misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed vectors push the expected
// MEM/WB contents, a monitor pops and compares after every rising edge.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemReadM, MemWriteM, MemToRegM;
  logic [4:0]  RD_M;
  logic [63:0] ALU_ResultM, WriteDataM;
  logic        StallM, dmem_req, dmem_we;
  logic [11:0] dmem_addr;
  logic [63:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        RegWriteW, MemToRegW, MisalignW;
  logic [4:0]  RD_W;
  logic [63:0] ALU_ResultW, ReadDataW;

  typedef struct {
    logic        reg_write;
    logic        mem_to_reg;
    logic [4:0]  rd;
    logic [63:0] alu_result;
    logic [63:0] read_data;
    logic        misalign;
    logic        bubble;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk         (clk),
    .reset       (reset),
    .RegWriteM   (RegWriteM),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .MemToRegM   (MemToRegM),
    .RD_M        (RD_M),
    .ALU_ResultM (ALU_ResultM),
    .WriteDataM  (WriteDataM),
    .StallM      (StallM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .RegWriteW   (RegWriteW),
    .MemToRegW   (MemToRegW),
    .RD_W        (RD_W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .MisalignW   (MisalignW)
  );

  // One comparison: count it, report it if it differs
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mkW(input logic rw, input logic m2r, input logic [4:0] rd,
                               input logic [63:0] alu, input logic [63:0] rdat, input logic mis);
    exp_t e;
    e.reg_write  = rw;
    e.mem_to_reg = m2r;
    e.rd         = rd;
    e.alu_result = alu;
    e.read_data  = rdat;
    e.misalign   = mis;
    e.bubble     = 1'b0;
    return e;
  endfunction

  function automatic exp_t mkBubble();
    exp_t e;
    e = mkW(1'b0, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    e.bubble = 1'b1;
    return e;
  endfunction

  // Drive one cycle of *M inputs and memory response, check the combinational
  // stall and the current request, and queue what MEM/WB must hold after the edge
  task automatic applyStimulus(input logic rw, input logic mr, input logic mw, input logic m2r,
                               input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] wd,
                               input logic ack, input logic [63:0] rdata,
                               input logic exp_stall, input logic exp_req, input exp_t e);
    @(negedge clk);
    RegWriteM   = rw;
    MemReadM    = mr;
    MemWriteM   = mw;
    MemToRegM   = m2r;
    RD_M        = rd;
    ALU_ResultM = alu;
    WriteDataM  = wd;
    dmem_ack    = ack;
    dmem_rdata  = rdata;
    #1;
    checkOutput("StallM", {63'd0, StallM}, {63'd0, exp_stall});
    checkOutput("dmem_req", {63'd0, dmem_req}, {63'd0, exp_req});
    exp_q.push_back(e);
  endtask

  task automatic idleInputs();
    RegWriteM = 0; MemReadM = 0; MemWriteM = 0; MemToRegM = 0;
    RD_M = 0; ALU_ResultM = 0; WriteDataM = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Monitor: after each rising edge compare MEM/WB against the oldest expectation
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("RegWriteW", {63'd0, RegWriteW}, {63'd0, e.reg_write});
      checkOutput("MisalignW", {63'd0, MisalignW}, {63'd0, e.misalign});
      if (!e.bubble) begin
        checkOutput("MemToRegW", {63'd0, MemToRegW}, {63'd0, e.mem_to_reg});
        checkOutput("RD_W", {59'd0, RD_W}, {59'd0, e.rd});
        checkOutput("ALU_ResultW", ALU_ResultW, e.alu_result);
        checkOutput("ReadDataW", ReadDataW, e.read_data);
      end
    end
  end

  // Directed sequence
  initial begin
    reset = 1'b0;
    idleInputs();
    repeat (2) @(negedge clk);
    checkOutput("reset dmem_req", {63'd0, dmem_req}, 64'd0);
    checkOutput("reset dmem_addr", {52'd0, dmem_addr}, 64'd0);
    checkOutput("reset RegWriteW", {63'd0, RegWriteW}, 64'd0);
    checkOutput("reset ALU_ResultW", ALU_ResultW, 64'd0);
    reset = 1'b1;

    // ALU pass-through
    applyStimulus(1, 0, 0, 0, 5, 30, 0, 0, 0, 0, 0, mkW(1, 0, 5, 30, 0, 0));

    // Load, four stall cycles, then ack with data
    applyStimulus(1, 1, 0, 1, 7, 64'h40, 0, 0, 0, 1, 0, mkBubble());
    applyStimulus(1, 1, 0, 1, 7, 64'h40, 0, 0, 0, 1, 1, mkBubble());
    checkOutput("load dmem_addr", {52'd0, dmem_addr}, 64'd8);
    checkOutput("load dmem_we", {63'd0, dmem_we}, 64'd0);
    applyStimulus(1, 1, 0, 1, 7, 64'h40, 0, 0, 0, 1, 1, mkBubble());
    applyStimulus(1, 1, 0, 1, 7, 64'h40, 0, 0, 0, 1, 1, mkBubble());
    applyStimulus(1, 1, 0, 1, 7, 64'h40, 0, 1, 64'hDEAD, 0, 1, mkW(1, 1, 7, 64'h40, 64'hDEAD, 0));

    // Store acknowledged in its first wait cycle
    applyStimulus(0, 0, 1, 0, 0, 64'h10, 64'h1234, 0, 0, 1, 0, mkBubble());
    applyStimulus(0, 0, 1, 0, 0, 64'h10, 64'h1234, 1, 64'hFFFF, 0, 1, mkW(0, 0, 0, 64'h10, 0, 0));
    checkOutput("store dmem_we", {63'd0, dmem_we}, 64'd1);
    checkOutput("store dmem_addr", {52'd0, dmem_addr}, 64'd2);
    checkOutput("store dmem_wdata", dmem_wdata, 64'h1234);

    // Load followed immediately by an add, then a nop with a stray ack
    applyStimulus(1, 1, 0, 1, 10, 64'h80, 0, 0, 0, 1, 0, mkBubble());
    applyStimulus(1, 1, 0, 1, 10, 64'h80, 0, 1, 64'h55, 0, 1, mkW(1, 1, 10, 64'h80, 64'h55, 0));
    applyStimulus(1, 0, 0, 0, 11, 99, 0, 0, 0, 0, 0, mkW(1, 0, 11, 99, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'h99, 0, 0, mkW(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mkW(0, 0, 0, 0, 0, 0));

    // Read and write both set behaves as a load
    applyStimulus(1, 1, 1, 1, 12, 64'h100, 64'hAAAA, 0, 0, 1, 0, mkBubble());
    applyStimulus(1, 1, 1, 1, 12, 64'h100, 64'hAAAA, 1, 64'h77, 0, 1, mkW(1, 1, 12, 64'h100, 64'h77, 0));
    checkOutput("rw dmem_we", {63'd0, dmem_we}, 64'd0);
    checkOutput("rw dmem_addr", {52'd0, dmem_addr}, 64'h20);

    // Reset while waiting for ack; the late ack must be ignored
    applyStimulus(1, 1, 0, 1, 3, 64'h20, 0, 0, 0, 1, 0, mkBubble());
    applyStimulus(1, 1, 0, 1, 3, 64'h20, 0, 0, 0, 1, 1, mkBubble());
    reset = 1'b0;
    #1;
    checkOutput("rst dmem_req", {63'd0, dmem_req}, 64'd0);
    checkOutput("rst dmem_addr", {52'd0, dmem_addr}, 64'd0);
    checkOutput("rst ReadDataW", ReadDataW, 64'd0);
    checkOutput("rst StallM load", {63'd0, StallM}, 64'd1);
    idleInputs();
    #1;
    checkOutput("rst StallM nop", {63'd0, StallM}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mkW(0, 0, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'hBAD, 0, 0, mkW(0, 0, 0, 0, 0, 0));
    applyStimulus(1, 0, 0, 0, 9, 64'h123, 0, 0, 0, 0, 0, mkW(1, 0, 9, 64'h123, 0, 0));

    // Misaligned load
`ifdef MISALIGN_TRAP_EN
    applyStimulus(1, 1, 0, 1, 4, 64'h43, 0, 0, 0, 0, 0, mkW(0, 1, 4, 64'h43, 0, 1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mkW(0, 0, 0, 0, 0, 0));
`else
    applyStimulus(1, 1, 0, 1, 4, 64'h43, 0, 0, 0, 1, 0, mkBubble());
    applyStimulus(1, 1, 0, 1, 4, 64'h43, 0, 1, 64'hBEEF, 0, 1, mkW(1, 1, 4, 64'h43, 64'hBEEF, 0));
    checkOutput("mis dmem_addr", {52'd0, dmem_addr}, 64'd8);
`endif

    @(negedge clk);
    idleInputs();
    repeat (2) @(negedge clk);
    checkOutput("queue drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
